// File: rtl/la_rle_decoder.sv
// Run-length decoder for logic-analyzer captures: expands {count, sample} AXIS packets
// into count repeats of the sample, with zero-bubble chaining between packets.
module la_rle_decoder #(
  parameter int pDATA_WIDTH   = 32,
  parameter int pSAMPLE_WIDTH = 24,
  parameter int pCNT_WIDTH    = 8,
  parameter int pTOTAL_WIDTH  = 32
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst_n,
  input  logic                     clr,
  input  logic [pDATA_WIDTH-1:0]   s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  input  logic [1:0]               s_tuser,
  output logic [pSAMPLE_WIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [1:0]               out_user,
  output logic [pTOTAL_WIDTH-1:0]  total_samples,
  output logic [pCNT_WIDTH-1:0]    zero_pkts
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t                   state, state_next;
  logic [pCNT_WIDTH-1:0]    remaining, remaining_next;
  logic [pSAMPLE_WIDTH-1:0] held_data;
  logic [1:0]               held_user;
  logic                     held_last;
  logic [pCNT_WIDTH-1:0]    pkt_count;
  logic [pSAMPLE_WIDTH-1:0] pkt_sample;
  logic                     accept, xfer, load, last_rep;

  assign pkt_count  = s_tdata[pDATA_WIDTH-1 -: pCNT_WIDTH];
  assign pkt_sample = s_tdata[pSAMPLE_WIDTH-1:0];
  assign last_rep   = (remaining == pCNT_WIDTH'(1));

  assign out_valid = (state == EXPAND);
  assign out_data  = held_data;
  assign out_user  = held_user;
  assign out_last  = out_valid && held_last && last_rep;
  assign xfer      = out_valid && out_ready;

  // Ready is held off during reset and clr so nothing can be accepted then.
  always_comb begin
    s_tready       = 1'b0;
    accept         = 1'b0;
    load           = 1'b0;
    state_next     = state;
    remaining_next = remaining;

    if (axis_rst_n && !clr) begin
      if (state == IDLE) s_tready = 1'b1;
      else               s_tready = out_ready && last_rep;
    end
    accept = s_tvalid && s_tready;

    case (state)
      IDLE: begin
        if (accept && pkt_count != '0) begin
          load           = 1'b1;
          remaining_next = pkt_count;
          state_next     = EXPAND;
        end
      end
      EXPAND: begin
        if (xfer) begin
          if (last_rep) begin
            if (accept && pkt_count != '0) begin
              load           = 1'b1;
              remaining_next = pkt_count;
            end else begin
              remaining_next = '0;
              state_next     = IDLE;
            end
          end else begin
            remaining_next = remaining - pCNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_next     = IDLE;
        remaining_next = '0;
      end
    endcase

    if (clr) begin
      load           = 1'b0;
      remaining_next = '0;
      state_next     = IDLE;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      held_data <= '0;
      held_user <= '0;
      held_last <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      if (load) begin
        held_data <= pkt_sample;
        held_user <= s_tuser;
        held_last <= s_tlast;
      end
    end
  end

  // Statistics counters saturate instead of wrapping.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      total_samples <= '0;
      zero_pkts     <= '0;
    end else if (clr) begin
      total_samples <= '0;
      zero_pkts     <= '0;
    end else begin
      if (xfer && total_samples != '1)
        total_samples <= total_samples + pTOTAL_WIDTH'(1);
      if (accept && pkt_count == '0 && zero_pkts != '1)
        zero_pkts <= zero_pkts + pCNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_la_rle_decoder.sv
// Directed self-checking bench for la_rle_decoder: one task per scenario,
// expected values computed by hand from the packet contents.
module tb_la_rle_decoder;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        clr;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [1:0]  s_tuser;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  out_user;
  logic [31:0] total_samples;
  logic [7:0]  zero_pkts;

  int n_cmp  = 0;
  int n_fail = 0;

  la_rle_decoder dut (
    .axis_clk      (axis_clk),
    .axis_rst_n    (axis_rst_n),
    .clr           (clr),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tlast       (s_tlast),
    .s_tuser       (s_tuser),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .out_user      (out_user),
    .total_samples (total_samples),
    .zero_pkts     (zero_pkts)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic do_clr();
    s_tvalid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    axis_rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_tready: got %b expected 0", s_tready); end
    n_cmp++; if (out_data !== 24'h0 || out_user !== 2'b0 || out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_outs: data %h user %b last %b expected 0", out_data, out_user, out_last); end
    n_cmp++; if (total_samples !== 32'h0 || zero_pkts !== 8'h0) begin n_fail++; $display("[TB] FAIL rst_counters: total %0d zero %0d expected 0", total_samples, zero_pkts); end
    tick();
    tick();
    axis_rst_n = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_tready: got %b expected 1", s_tready); end
    tick();
  endtask

  task automatic test_single();
    do_clr();
    s_tdata = 32'h03ABCDEF; s_tvalid = 1'b1; s_tlast = 1'b0; s_tuser = 2'b10; out_ready = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_tready: got %b expected 1", s_tready); end
    tick();
    s_tvalid = 1'b0; s_tuser = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (out_valid !== (i < 3)) begin n_fail++; $display("[TB] FAIL single_valid[%0d]: got %b expected %b", i, out_valid, (i < 3)); end
      if (i < 3) begin
        n_cmp++; if (out_data !== 24'hABCDEF || out_user !== 2'b10) begin n_fail++; $display("[TB] FAIL single_data[%0d]: got %h/%b expected abcdef/10", i, out_data, out_user); end
      end
      tick();
    end
    n_cmp++; if (total_samples !== 32'd3) begin n_fail++; $display("[TB] FAIL single_total: got %0d expected 3", total_samples); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_data [3] = '{24'h1, 24'h1, 24'h2};
    logic        exp_last [3] = '{1'b0, 1'b0, 1'b1};
    logic        exp_rdy  [2] = '{1'b0, 1'b1};
    do_clr();
    out_ready = 1'b1;
    s_tdata = 32'h02000001; s_tvalid = 1'b1; s_tlast = 1'b0;
    tick();
    s_tdata = 32'h01000002; s_tlast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i < 3) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_data[i] || out_last !== exp_last[i]) begin n_fail++; $display("[TB] FAIL chain_sample[%0d]: got v%b %h l%b expected v1 %h l%b", i, out_valid, out_data, out_last, exp_data[i], exp_last[i]); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL chain_end_valid: got %b expected 0", out_valid); end
      end
      if (i < 2) begin
        n_cmp++; if (s_tready !== exp_rdy[i]) begin n_fail++; $display("[TB] FAIL chain_tready[%0d]: got %b expected %b", i, s_tready, exp_rdy[i]); end
      end
      tick();
      if (i == 1) begin s_tvalid = 1'b0; s_tlast = 1'b0; end
    end
    n_cmp++; if (total_samples !== 32'd3) begin n_fail++; $display("[TB] FAIL chain_total: got %0d expected 3", total_samples); end
  endtask

  task automatic test_backpressure();
    logic pat     [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int   xfers = 0;
    do_clr();
    out_ready = 1'b1;
    s_tdata = 32'h04123456; s_tvalid = 1'b1; s_tlast = 1'b0;
    tick();
    s_tvalid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'h123456) begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got v%b %h expected v1 123456", i, out_valid, out_data); end
      n_cmp++; if (s_tready !== exp_rdy[i]) begin n_fail++; $display("[TB] FAIL bp_tready[%0d]: got %b expected %b", i, s_tready, exp_rdy[i]); end
      if (out_valid && out_ready) xfers++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (xfers != 4 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_xfers: got %0d (valid %b) expected 4 (valid 0)", xfers, out_valid); end
    n_cmp++; if (total_samples !== 32'd4) begin n_fail++; $display("[TB] FAIL bp_total: got %0d expected 4", total_samples); end
  endtask

  task automatic test_zero_count();
    do_clr();
    out_ready = 1'b1;
    s_tdata = 32'h00FFFFFF; s_tvalid = 1'b1; s_tlast = 1'b1;
    tick();
    s_tdata = 32'h01000007; s_tlast = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || zero_pkts !== 8'd1) begin n_fail++; $display("[TB] FAIL zero_drop: valid %b zero %0d expected 0/1", out_valid, zero_pkts); end
    tick();
    s_tvalid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'h7 || out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_next: got v%b %h l%b expected v1 000007 l0", out_valid, out_data, out_last); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || total_samples !== 32'd1 || zero_pkts !== 8'd1) begin n_fail++; $display("[TB] FAIL zero_after: v%b total %0d zero %0d expected 0/1/1", out_valid, total_samples, zero_pkts); end
    // count==0 arriving in a chained slot ends expansion
    s_tdata = 32'h01000009; s_tvalid = 1'b1;
    tick();
    s_tdata = 32'h00000000;
    #1;
    n_cmp++; if (s_tready !== 1'b1 || out_data !== 24'h9) begin n_fail++; $display("[TB] FAIL zero_chain_slot: tready %b data %h expected 1/000009", s_tready, out_data); end
    tick();
    s_tvalid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || zero_pkts !== 8'd2 || total_samples !== 32'd2) begin n_fail++; $display("[TB] FAIL zero_chain: v%b zero %0d total %0d expected 0/2/2", out_valid, zero_pkts, total_samples); end
  endtask

  task automatic test_zero_saturate();
    do_clr();
    s_tdata = 32'h00000000; s_tvalid = 1'b1; s_tlast = 1'b0;
    repeat (260) tick();
    s_tvalid = 1'b0;
    #1;
    n_cmp++; if (zero_pkts !== 8'd255 || out_valid !== 1'b0 || total_samples !== 32'd0) begin n_fail++; $display("[TB] FAIL zero_saturate: zero %0d v%b total %0d expected 255/0/0", zero_pkts, out_valid, total_samples); end
  endtask

  task automatic test_max_count();
    int seen = 0;
    int bad  = 0;
    do_clr();
    out_ready = 1'b1;
    s_tdata = 32'hFF00000A; s_tvalid = 1'b1; s_tlast = 1'b0;
    tick();
    s_tvalid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!out_valid) break;
      seen++;
      if (out_data !== 24'h00000A) bad++;
      tick();
    end
    n_cmp++; if (seen != 255 || bad != 0) begin n_fail++; $display("[TB] FAIL max_samples: got %0d (bad data %0d) expected 255 (0)", seen, bad); end
    n_cmp++; if (total_samples !== 32'd255) begin n_fail++; $display("[TB] FAIL max_total: got %0d expected 255", total_samples); end
  endtask

  task automatic follow_up(input string tag);
    s_tdata = 32'h01000066; s_tvalid = 1'b1; s_tlast = 1'b0;
    tick();
    s_tvalid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'h66) begin n_fail++; $display("[TB] FAIL %s_followup: got v%b %h expected v1 000066", tag, out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || total_samples !== 32'd1) begin n_fail++; $display("[TB] FAIL %s_followup_end: v%b total %0d expected 0/1", tag, out_valid, total_samples); end
  endtask

  task automatic test_clr_mid();
    do_clr();
    out_ready = 1'b1;
    s_tdata = 32'h10000055; s_tvalid = 1'b1; s_tlast = 1'b0;
    tick();
    repeat (5) tick();
    clr = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_tready: got %b expected 0", s_tready); end
    tick();
    clr = 1'b0; s_tvalid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || total_samples !== 32'd0 || zero_pkts !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_flush: v%b total %0d zero %0d expected 0/0/0", out_valid, total_samples, zero_pkts); end
    follow_up("clr");
  endtask

  task automatic test_reset_mid();
    do_clr();
    out_ready = 1'b1;
    s_tdata = 32'h10000055; s_tvalid = 1'b1; s_tlast = 1'b0;
    tick();
    s_tvalid = 1'b0;
    repeat (5) tick();
    axis_rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || s_tready !== 1'b0 || out_data !== 24'h0 || total_samples !== 32'd0) begin n_fail++; $display("[TB] FAIL rstmid_async: v%b rdy %b data %h total %0d expected all 0", out_valid, s_tready, out_data, total_samples); end
    tick();
    axis_rst_n = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_release: rdy %b v%b expected 1/0", s_tready, out_valid); end
    repeat (3) tick();
    n_cmp++; if (out_valid !== 1'b0 || total_samples !== 32'd0) begin n_fail++; $display("[TB] FAIL rstmid_idle: v%b total %0d expected 0/0", out_valid, total_samples); end
    follow_up("rstmid");
  endtask

  initial begin
    clr = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 2'b00; out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero_count();
    test_zero_saturate();
    test_max_count();
    test_clr_mid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
